fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the load-use stall control unit.
- Owns the PC and issues req/ack fetches to instruction memory. Loads IF/ID under PC_WriteEn / IFID_WriteEn from the stall unit, and flushes on taken branch.
- Decodes IFID_rn / IFID_rm / IFID_rd from the held instruction and feeds them to the stall unit and the ID stage.

---
 rtl/fetch_stage.sv | 214 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, req/ack memory handshake and IF/ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds stall/flush cycle counters.
module fetch_stage #(
    parameter int unsigned          ADDR_W   = 64,
    parameter int unsigned          INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                PC_WriteEn,
    input  logic                IFID_WriteEn,
    input  logic                Branch_Taken,
    input  logic [ADDR_W-1:0]   Branch_Target,
    output logic                IMem_Req,
    output logic [ADDR_W-1:0]   IMem_Addr,
    input  logic                IMem_Ack,
    input  logic [INSTR_W-1:0]  IMem_RData,
    output logic [ADDR_W-1:0]   IFID_PC,
    output logic [INSTR_W-1:0]  IFID_Instr,
    output logic                IFID_Valid,
    output logic [4:0]          IFID_rd,
    output logic [4:0]          IFID_rn,
    output logic [4:0]          IFID_rm,
    output logic                Fetch_Busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         Stall_Cnt,
    output logic [31:0]         Flush_Cnt
`endif
);

    // WAIT is ISSUE with the request still outstanding; it behaves like ISSUE but reports busy.
    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    state_t               state_r;
    state_t               nextState_s;
    logic [ADDR_W-1:0]    pc_r;
    logic [ADDR_W-1:0]    pcNext_s;
    logic [ADDR_W-1:0]    discardAddr_r;
    logic [INSTR_W-1:0]   holdInstr_r;
    logic [ADDR_W-1:0]    ifidPc_r;
    logic [INSTR_W-1:0]   ifidInstr_r;
    logic                 ifidValid_r;
    logic                 fetching_s;
    logic                 accept_s;
    logic                 capture_s;
    logic                 release_s;

    // Handshake qualifiers shared by the FSM and the datapath
    always_comb begin
        fetching_s = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
        accept_s   = fetching_s && IMem_Ack && IFID_WriteEn && !Branch_Taken;
        capture_s  = fetching_s && IMem_Ack && !IFID_WriteEn && !Branch_Taken;
        release_s  = (state_r == ST_HOLD) && IFID_WriteEn && !Branch_Taken;
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= ST_ISSUE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic; Branch_Taken outranks Ack and stall
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_ISSUE, ST_WAIT: begin
                if (Branch_Taken) begin
                    nextState_s = IMem_Ack ? ST_ISSUE : ST_DISCARD;
                end else if (IMem_Ack) begin
                    nextState_s = IFID_WriteEn ? ST_ISSUE : ST_HOLD;
                end else begin
                    nextState_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (Branch_Taken || IFID_WriteEn) begin
                    nextState_s = ST_ISSUE;
                end else begin
                    nextState_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (IMem_Ack) begin
                    nextState_s = ST_ISSUE;
                end else begin
                    nextState_s = ST_DISCARD;
                end
            end
            default: nextState_s = ST_ISSUE;
        endcase
    end

    // FSM outputs: request, address and busy flag
    always_comb begin
        IMem_Req   = 1'b0;
        IMem_Addr  = pc_r;
        Fetch_Busy = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                IMem_Req = !Reset;
            end
            ST_WAIT: begin
                IMem_Req   = !Reset;
                Fetch_Busy = 1'b1;
            end
            ST_HOLD: begin
                Fetch_Busy = 1'b1;
            end
            ST_DISCARD: begin
                IMem_Req   = !Reset;
                IMem_Addr  = discardAddr_r;
                Fetch_Busy = 1'b1;
            end
            default: begin
                IMem_Req = 1'b0;
            end
        endcase
    end

    // Next PC; a stalled PC refetches the same address
    always_comb begin
        pcNext_s = pc_r;
        if (Branch_Taken) begin
            pcNext_s = Branch_Target;
        end else if ((accept_s || release_s) && PC_WriteEn) begin
            pcNext_s = pc_r + PC_STEP;
        end else begin
            pcNext_s = pc_r;
        end
    end

    // PC, outstanding-address latch and hold buffer
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_r          <= RESET_PC;
            discardAddr_r <= {ADDR_W{1'b0}};
            holdInstr_r   <= {INSTR_W{1'b0}};
        end else begin
            pc_r <= pcNext_s;
            if (fetching_s && Branch_Taken && !IMem_Ack) begin
                discardAddr_r <= pc_r;
            end
            if (Branch_Taken) begin
                holdInstr_r <= {INSTR_W{1'b0}};
            end else if (capture_s) begin
                holdInstr_r <= IMem_RData;
            end
        end
    end

    // IF/ID register; a cycle with IFID_WriteEn=1 but nothing delivered becomes a bubble
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ifidPc_r    <= {ADDR_W{1'b0}};
            ifidInstr_r <= {INSTR_W{1'b0}};
            ifidValid_r <= 1'b0;
        end else if (Branch_Taken) begin
            ifidValid_r <= 1'b0;
        end else if (accept_s) begin
            ifidPc_r    <= pc_r;
            ifidInstr_r <= IMem_RData;
            ifidValid_r <= 1'b1;
        end else if (release_s) begin
            ifidPc_r    <= pc_r;
            ifidInstr_r <= holdInstr_r;
            ifidValid_r <= 1'b1;
        end else if (IFID_WriteEn) begin
            ifidValid_r <= 1'b0;
        end
    end

    assign IFID_PC    = ifidPc_r;
    assign IFID_Instr = ifidInstr_r;
    assign IFID_Valid = ifidValid_r;
    // Decoded without Valid gating: a stale flushed value can only cause a spurious stall
    assign IFID_rd    = ifidInstr_r[4:0];
    assign IFID_rn    = ifidInstr_r[9:5];
    assign IFID_rm    = ifidInstr_r[20:16];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCnt_r;
    logic [31:0] flushCnt_r;

    // Free-running wrap-around event counters
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stallCnt_r <= 32'd0;
            flushCnt_r <= 32'd0;
        end else begin
            if (!IFID_WriteEn) begin
                stallCnt_r <= stallCnt_r + 32'd1;
            end
            if (Branch_Taken) begin
                flushCnt_r <= flushCnt_r + 32'd1;
            end
        end
    end

    assign Stall_Cnt = stallCnt_r;
    assign Flush_Cnt = flushCnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: IF/ID results go through a scoreboard queue,
// handshake outputs are checked directly against hand-derived constants.
module tb_fetch_stage;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INSTR_W = 32;
    localparam logic [63:0] RST_PC = 64'h100;

    logic                CLK = 1'b0;
    logic                Reset;
    logic                PC_WriteEn;
    logic                IFID_WriteEn;
    logic                Branch_Taken;
    logic [ADDR_W-1:0]   Branch_Target;
    logic                IMem_Req;
    logic [ADDR_W-1:0]   IMem_Addr;
    logic                IMem_Ack;
    logic [INSTR_W-1:0]  IMem_RData;
    logic [ADDR_W-1:0]   IFID_PC;
    logic [INSTR_W-1:0]  IFID_Instr;
    logic                IFID_Valid;
    logic [4:0]          IFID_rd;
    logic [4:0]          IFID_rn;
    logic [4:0]          IFID_rm;
    logic                Fetch_Busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]         Stall_Cnt;
    logic [31:0]         Flush_Cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        tag;
        logic [63:0]  pc;
        logic [31:0]  instr;
        logic         valid;
    } ifid_exp_t;

    ifid_exp_t sb[$];

    fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC)) dut (
        .CLK(CLK), .Reset(Reset), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_RData(IMem_RData),
        .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid),
        .IFID_rd(IFID_rd), .IFID_rn(IFID_rn), .IFID_rm(IFID_rm), .Fetch_Busy(Fetch_Busy)
`ifdef FETCH_PERF_CNT_EN
        , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memFn(input logic [63:0] a);
        if (a == 64'h100) return 32'h8B02_0020;
        return {8'hE0, a[23:0]};
    endfunction

    assign IMem_RData = memFn(IMem_Addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectIfid(input string tag, input logic [63:0] pc,
                              input logic [31:0] instr, input logic valid);
        ifid_exp_t e;
        e.tag = tag; e.pc = pc; e.instr = instr; e.valid = valid;
        sb.push_back(e);
    endtask

    // Advance one edge, then retire every expectation queued for that edge.
    task automatic tick();
        ifid_exp_t e;
        @(posedge CLK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".pc"}, IFID_PC, e.pc);
            check({e.tag, ".instr"}, {32'd0, IFID_Instr}, {32'd0, e.instr});
            check({e.tag, ".valid"}, {63'd0, IFID_Valid}, {63'd0, e.valid});
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic ifwe, input logic pcwe,
                         input logic br, input logic [63:0] tgt);
        Reset = rst; IMem_Ack = ack; IFID_WriteEn = ifwe; PC_WriteEn = pcwe;
        Branch_Taken = br; Branch_Target = tgt;
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        check("req_in_reset", {63'd0, IMem_Req}, 64'd0);
        tick();
        tick();
        check("rst.valid", {63'd0, IFID_Valid}, 64'd0);
        check("rst.pc", IFID_PC, 64'd0);
        check("rst.busy", {63'd0, Fetch_Busy}, 64'd0);
        check("rst.addr", IMem_Addr, 64'h100);

        // zero-wait streaming
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        check("s0.req", {63'd0, IMem_Req}, 64'd1);
        expectIfid("s0", 64'h100, 32'h8B02_0020, 1'b1);
        tick();
        check("dec.rd", {59'd0, IFID_rd}, 64'd0);
        check("dec.rn", {59'd0, IFID_rn}, 64'd1);
        check("dec.rm", {59'd0, IFID_rm}, 64'd2);
        check("s1.addr", IMem_Addr, 64'h104);
        expectIfid("s1", 64'h104, 32'hE000_0104, 1'b1);
        tick();
        expectIfid("s2", 64'h108, 32'hE000_0108, 1'b1);
        tick();

        // stall with Ack on 0x10C: hold buffer, then release
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        check("h0.addr", IMem_Addr, 64'h10C);
        expectIfid("h0", 64'h108, 32'hE000_0108, 1'b1);
        tick();
        check("h.busy", {63'd0, Fetch_Busy}, 64'd1);
        check("h.req", {63'd0, IMem_Req}, 64'd0);
        expectIfid("h1", 64'h108, 32'hE000_0108, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        expectIfid("hrel", 64'h10C, 32'hE000_010C, 1'b1);
        tick();
        check("hrel.addr", IMem_Addr, 64'h110);
        check("hrel.busy", {63'd0, Fetch_Busy}, 64'd0);

        // branch while a request is outstanding -> DISCARD
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h200);
        expectIfid("d0", 64'h10C, 32'hE000_010C, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        check("d1.addr", IMem_Addr, 64'h110);
        check("d1.busy", {63'd0, Fetch_Busy}, 64'd1);
        expectIfid("d1", 64'h10C, 32'hE000_010C, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        check("d2.addr", IMem_Addr, 64'h110);
        check("d2.req", {63'd0, IMem_Req}, 64'd1);
        expectIfid("d2", 64'h10C, 32'hE000_010C, 1'b0);
        tick();
        check("d3.addr", IMem_Addr, 64'h200);
        check("d3.req", {63'd0, IMem_Req}, 64'd1);
        expectIfid("d3", 64'h200, 32'hE000_0200, 1'b1);
        tick();

        // branch + stall + Ack in one cycle: branch wins, no HOLD
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h300);
        expectIfid("bs", 64'h200, 32'hE000_0200, 1'b0);
        tick();
        check("bs.busy", {63'd0, Fetch_Busy}, 64'd0);
        check("bs.addr", IMem_Addr, 64'h300);
        check("bs.req", {63'd0, IMem_Req}, 64'd1);

        // reset from WAIT
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        expectIfid("w0", 64'h200, 32'hE000_0200, 1'b0);
        tick();
        check("w.busy", {63'd0, Fetch_Busy}, 64'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        check("w.reqrst", {63'd0, IMem_Req}, 64'd0);
        expectIfid("wrst", 64'h0, 32'h0, 1'b0);
        tick();
        check("wrst.addr", IMem_Addr, 64'h100);
        check("wrst.busy", {63'd0, Fetch_Busy}, 64'd0);

        // reset from HOLD
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        check("hh.busy", {63'd0, Fetch_Busy}, 64'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        expectIfid("hrst", 64'h0, 32'h0, 1'b0);
        tick();
        check("hrst.busy", {63'd0, Fetch_Busy}, 64'd0);

        // reset from DISCARD
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        expectIfid("x0", 64'h100, 32'h8B02_0020, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h400);
        expectIfid("x1", 64'h100, 32'h8B02_0020, 1'b0);
        tick();
        check("x.busy", {63'd0, Fetch_Busy}, 64'd1);
        check("x.addr", IMem_Addr, 64'h104);
`ifdef FETCH_PERF_CNT_EN
        check("cnt.flush", {32'd0, Flush_Cnt}, 64'd1);
        check("cnt.stall", {32'd0, Stall_Cnt}, 64'd0);
`endif
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        expectIfid("xrst", 64'h0, 32'h0, 1'b0);
        tick();
        check("xrst.addr", IMem_Addr, 64'h100);
        check("xrst.busy", {63'd0, Fetch_Busy}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("cntrst.flush", {32'd0, Flush_Cnt}, 64'd0);
        check("cntrst.stall", {32'd0, Stall_Cnt}, 64'd0);
`endif

        // PC wrap at 2^64
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        expectIfid("wr0", 64'h0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        check("wr.addr", IMem_Addr, 64'hFFFF_FFFF_FFFF_FFFC);
        expectIfid("wr1", 64'hFFFF_FFFF_FFFF_FFFC, 32'hE0FF_FFFC, 1'b1);
        tick();
        check("wr.next", IMem_Addr, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
